muldiv_sequencer: RTL
=====================

Name: muldiv_sequencer

Overview:
Multi-cycle multiply/divide controller that sits beside the ALU in the execute stage and owns the architectural HI/LO registers. When EX holds a MULT/MULTU/DIV/DIVU instruction, it latches the two operands and runs a WIDTH-cycle iterative shift-add or restoring-divide datapath. While it runs, it raises a stall to the hazard unit so the pipeline holds the instruction in EX. It also services MTHI/MTLO writes and supplies HI/LO to the MFHI/MFLO path.

Parameters:
WIDTH, 32, operand width; iteration count equals WIDTH.

Ports:
clk  in  1  pipeline clock.
rst  in  1  reset.
start  in  1  EX holds a mult/div instruction; level, held by the stall.
op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
op_a  in  WIDTH  Dato1 (rs): multiplicand / dividend.
op_b  in  WIDTH  Dato2 (rt): multiplier / divisor.
flush  in  1  cancel the in-flight operation (branch/exception squash).
wr_hi  in  1  MTHI write strobe.
wr_lo  in  1  MTLO write strobe.
wr_data  in  WIDTH  MTHI/MTLO data.
stall  out  1  hold IF/ID/EX; combinational.
busy  out  1  registered; high in CALC and FIN.
done  out  1  one-cycle completion pulse.
hi  out  WIDTH  HI register.
lo  out  WIDTH  LO register.

Behaviour:
- One clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state IDLE; hi=0, lo=0, busy=0, done=0, iteration counter=0; internal operand/accumulator registers cleared.
- FSM states are IDLE, CALC, FIN, DONE.
  - IDLE: if start=1 and flush=0, latch op, sign flags and operand magnitudes (absolute values only for signed ops), clear the accumulator and go to CALC. Otherwise stay in IDLE.
  - CALC: one shift-add (multiply) or one shift-subtract-restore (divide) step per cycle, for exactly WIDTH cycles. Counter runs WIDTH-1 down to 0; when it reaches 0, go to FIN.
  - FIN: apply sign correction and write HI/LO at the end of this cycle, then go to DONE.
  - DONE: done=1 for this single cycle; start is ignored. Go to IDLE next.
- Latency: start seen at cycle N; CALC occupies N+1..N+WIDTH; FIN is N+WIDTH+1; done and new HI/LO are visible at N+WIDTH+2, which is N+34 for the default.
- stall = (state==CALC) | (state==FIN) | (state==IDLE & start & ~flush).
  - stall is 0 in DONE, so the pipeline advances out of EX at the end of the DONE cycle. This prevents a retrigger.
- Multiply results: {hi,lo} = 2*WIDTH-bit product.
  - Signed product is formed from magnitudes and negated (two's complement, 2*WIDTH wide) when the operand signs differ.
- Divide results: lo = quotient, hi = remainder.
  - Signed quotient is negated when the operand signs differ.
  - Signed remainder takes the sign of the dividend.
  - Most-negative / -1 gives lo = 0x80000000, hi = 0, with no trap.
- Divide by zero (op_b=0), both signed and unsigned: lo = all ones, hi = op_a as latched, no sign correction, same latency.
- flush: in CALC or FIN, return to IDLE next cycle; hi/lo are unchanged and done is not asserted. In IDLE it suppresses acceptance. In DONE it has no effect.
- wr_hi / wr_lo:
  - Accepted in every state and take effect at the next edge.
  - If written during CALC, the FIN result overwrites the written value.
  - If a write coincides with FIN, the FIN result wins.
  - wr_hi and wr_lo together write both registers.
- Reset asserted mid-operation returns everything to the reset values immediately, without waiting for a clock edge.
- start in CALC/FIN/DONE never relatches operands.

Test Plan:
- MULTU 0xFFFFFFFF * 0xFFFFFFFF, start at cycle N → stall high N..N+33; done=1 only at N+34, with hi=0xFFFFFFFE, lo=0x00000001; stall=0 at N+34.
- MULT -3 * 7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB. Then DIV -7 / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU 100 / 0 → lo=0xFFFFFFFF, hi=0x00000064, at the same 34-cycle latency. DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- flush in cycle N+10 of a DIVU → state IDLE at N+11, busy=0, done never pulses, hi/lo keep their prior values.
- Write wr_lo=1, wr_data=0x1234 in IDLE → lo=0x1234 next cycle. Then MULTU 2*3 with wr_hi pulsed mid-CALC → final hi=0, lo=6.
- Assert rst asynchronously at N+20 of a MULT → hi=lo=0, busy=0, stall=start. After release, a new start is accepted normally.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
// Multi-cycle multiply/divide unit beside the execute-stage ALU. Owns the
// architectural HI/LO registers. A MULT/MULTU/DIV/DIVU held in EX is latched
// and run through WIDTH iterations of shift-add (multiply) or restoring
// divide, while stall holds the pipeline. Also serves MTHI/MTLO writes.
//
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   start            EX holds a mult/div instruction (level)
//   op               00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   op_a, op_b       rs / rt operands
//   flush            squash the in-flight operation
//   wr_hi, wr_lo     MTHI / MTLO strobes, data on wr_data
//   stall            combinational pipeline hold
//   busy             registered, high in CALC and FIN
//   done             one-cycle completion pulse
//   hi, lo           HI / LO registers
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             flush,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wr_data,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int W2    = 2 * WIDTH;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIN, DONE} state_t;

  state_t state, state_nxt;

  logic             is_div;
  logic             neg_res;   // quotient / product negated
  logic             neg_rem;   // remainder takes dividend sign
  logic             div_zero;
  logic [WIDTH-1:0] a_raw;     // dividend as latched, for divide-by-zero HI
  logic [WIDTH-1:0] opnd;      // multiplicand or divisor magnitude
  logic [WIDTH-1:0] acc;       // product high half / partial remainder
  logic [WIDTH-1:0] mq;        // multiplier / quotient shift register
  logic [CNT_W-1:0] cnt;

  logic             accept;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH-1:0] div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] acc_step, mq_step;
  logic [W2-1:0]    prod_fin;
  logic [WIDTH-1:0] hi_fin, lo_fin;

  // Absolute value for signed ops; the most negative value maps to itself,
  // which is its correct unsigned magnitude.
  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v,
                                                 input logic is_signed);
    if (is_signed && v < 0) return $unsigned(-v);
    return $unsigned(v);
  endfunction

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v, input logic en);
    return en ? (~v + WIDTH'(1)) : v;
  endfunction

  function automatic logic [W2-1:0] neg_2w(input logic [W2-1:0] v, input logic en);
    return en ? (~v + W2'(1)) : v;
  endfunction

  assign accept = (state == IDLE) && start && !flush;
  assign stall  = (state == CALC) || (state == FIN) || accept;

  always_comb begin
    mul_sum   = {1'b0, acc} + (mq[0] ? {1'b0, opnd} : '0);
    div_shift = {acc, mq[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, opnd};
    // Only used when div_ge, so the difference always fits in WIDTH bits.
    div_diff  = div_shift[WIDTH-1:0] - opnd;
    if (is_div) begin
      acc_step = div_ge ? div_diff : div_shift[WIDTH-1:0];
      mq_step  = {mq[WIDTH-2:0], div_ge};
    end else begin
      acc_step = mul_sum[WIDTH:1];
      mq_step  = {mul_sum[0], mq[WIDTH-1:1]};
    end
  end

  always_comb begin
    prod_fin = neg_2w({acc, mq}, neg_res);
    if (is_div) begin
      if (div_zero) begin
        hi_fin = a_raw;
        lo_fin = '1;
      end else begin
        hi_fin = neg_w(acc, neg_rem);
        lo_fin = neg_w(mq, neg_res);
      end
    end else begin
      hi_fin = prod_fin[W2-1:WIDTH];
      lo_fin = prod_fin[WIDTH-1:0];
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = CALC;
      CALC:    if (flush) state_nxt = IDLE;
               else if (cnt == '0) state_nxt = FIN;
      FIN:     state_nxt = flush ? IDLE : DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == CALC) || (state_nxt == FIN);
      done  <= (state_nxt == DONE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      a_raw    <= '0;
      opnd     <= '0;
      acc      <= '0;
      mq       <= '0;
      cnt      <= '0;
    end else if (accept) begin
      is_div   <= op[1];
      neg_res  <= !op[0] && (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
      neg_rem  <= !op[0] && op_a[WIDTH-1];
      div_zero <= op[1] && (op_b == '0);
      a_raw    <= op_a;
      acc      <= '0;
      cnt      <= CNT_LAST;
      if (op[1]) begin
        opnd <= magnitude(op_b, !op[0]);
        mq   <= magnitude(op_a, !op[0]);
      end else begin
        opnd <= magnitude(op_a, !op[0]);
        mq   <= magnitude(op_b, !op[0]);
      end
    end else if (state == CALC) begin
      acc <= acc_step;
      mq  <= mq_step;
      cnt <= cnt - CNT_W'(1);
    end
  end

  // The FIN result has priority over a coincident MTHI/MTLO write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi <= '0;
      lo <= '0;
    end else if (state == FIN && !flush) begin
      hi <= hi_fin;
      lo <= lo_fin;
    end else begin
      if (wr_hi) hi <= wr_data;
      if (wr_lo) lo <= wr_data;
    end
  end

endmodule
